// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
// FSM state encoding, watchdog width and frame width.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int TXQ_WDOG_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_TRIG = 3'd2,
    ST_BUSY = 3'd3,
    ST_GAP  = 3'd4
  } txq_state_e;

endpackage

// File: rtl/sync_ff2.sv
// Generic 2-flop synchroniser with synchronous active-low reset.
// Ports: clk, rst_n, d (async input), q (synchronised output).
module sync_ff2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus transmit sequencer feeding a UART sender.
// Ports: sysclk, reset (sync, active-low); wr_en/wr_data push side
// with full/empty/count; TX_DATA/trigger/enable to the sender;
// tx_state/tx_finish async status from the sender.
// Optional UART_TXQ_OVERFLOW_FLAG_EN adds ovf_clr in, overflow out.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              trigger,
  output logic              enable,
  input  logic              tx_state,
  input  logic              tx_finish
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
  ,input  logic             ovf_clr
  ,output logic             overflow
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              trigger_q, trigger_d;
  logic              enable_q, enable_d;
  logic              fin_prev_q, fin_prev_d;
  logic [TXQ_WDOG_W-1:0] wdog_q, wdog_d;
  txq_state_e        state_q, state_d;

  logic busy_s, fin_s, fin_rise;
  logic push, pop;

  sync_ff2 u_sync_busy (
    .clk   (sysclk),
    .rst_n (reset),
    .d     (tx_state),
    .q     (busy_s)
  );

  sync_ff2 u_sync_fin (
    .clk   (sysclk),
    .rst_n (reset),
    .d     (tx_finish),
    .q     (fin_s)
  );

  assign fin_rise = fin_s & ~fin_prev_q;
  assign push     = wr_en & ~full_q;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    wdog_d    = '0;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        tx_data_d = mem_q[rd_ptr_q];
        pop       = 1'b1;
        state_d   = ST_TRIG;
      end
      ST_TRIG: begin
        wdog_d = wdog_q + 1'b1;
        if (busy_s) begin
          state_d = ST_BUSY;
        end else if (wdog_q == '1) begin
          // Sender never went busy: drop this byte.
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (fin_rise) state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = empty_q ? ST_IDLE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs registered from next state: glitch-free to the sender.
    trigger_d  = (state_d == ST_TRIG);
    enable_d   = (state_d != ST_IDLE);
    fin_prev_d = fin_s;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge sysclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      tx_data_q  <= '0;
      trigger_q  <= 1'b0;
      enable_q   <= 1'b0;
      fin_prev_q <= 1'b0;
      wdog_q     <= '0;
      state_q    <= ST_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      tx_data_q  <= tx_data_d;
      trigger_q  <= trigger_d;
      enable_q   <= enable_d;
      fin_prev_q <= fin_prev_d;
      wdog_q     <= wdog_d;
      state_q    <= state_d;
    end
  end

`ifdef UART_TXQ_OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;

  // Set wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr)        ovf_d = 1'b0;
    if (wr_en && full_q) ovf_d = 1'b1;
  end

  always_ff @(posedge sysclk) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;
  assign TX_DATA = tx_data_q;
  assign trigger = trigger_q;
  assign enable  = enable_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue.
// Sender handshake is modelled by driving tx_state/tx_finish.
module tb_uart_tx_queue;

  logic       sysclk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic [7:0] TX_DATA;
  logic       trigger;
  logic       enable;
  logic       tx_state;
  logic       tx_finish;
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
  logic       ovf_clr;
  logic       overflow;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mq [$];
  logic [8:0] ops [20];
  logic [7:0] exp_b;

  uart_tx_queue dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .TX_DATA   (TX_DATA),
    .trigger   (trigger),
    .enable    (enable),
    .tx_state  (tx_state),
    .tx_finish (tx_finish)
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
    ,.ovf_clr  (ovf_clr)
    ,.overflow (overflow)
`endif
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_trig(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (trigger === 1'b1) seen = 1'b1;
    end
    check({tag, "_timeout"}, 32'(seen), 32'd1);
  endtask

  // Finish the frame in BUSY and capture the next one's byte.
  task automatic frame_step(input logic [7:0] exp,
                            input string tag);
    tx_finish = 1'b1;
    wait_trig(20, tag);
    check(tag, 32'(TX_DATA), 32'(exp));
    tx_finish = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    tx_state  = 1'b0;
    tx_finish = 1'b0;
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
    ovf_clr   = 1'b0;
`endif
    ops = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h100,
            9'h014, 9'h015, 9'h100, 9'h100, 9'h016,
            9'h100, 9'h100, 9'h100, 9'h017, 9'h018,
            9'h100, 9'h100, 9'h100, 9'h019, 9'h100};

    // Reset state
    repeat (2) tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_txdata", 32'(TX_DATA), 32'h00);
    check("rst_trig", 32'(trigger), 32'd0);
    check("rst_en", 32'(enable), 32'd0);
    reset = 1'b1;
    tick();

    // Single byte, minimum latency
    push(8'hA5);
    check("t1_count", 32'(count), 32'd1);
    check("t1_trig_n0", 32'(trigger), 32'd0);
    tick();
    check("t1_trig_n1", 32'(trigger), 32'd0);
    check("t1_en_n1", 32'(enable), 32'd1);
    tick();
    check("t1_trig_n2", 32'(trigger), 32'd1);
    check("t1_data", 32'(TX_DATA), 32'hA5);
    check("t1_empty", 32'(empty), 32'd1);
    tx_state = 1'b1;
    repeat (2) tick();
    check("t1_trig_hold", 32'(trigger), 32'd1);
    tick();
    check("t1_trig_drop", 32'(trigger), 32'd0);
    check("t1_en_busy", 32'(enable), 32'd1);
    tx_state  = 1'b0;
    tx_finish = 1'b1;
    repeat (3) tick();
    check("t1_en_gap", 32'(enable), 32'd1);
    tick();
    check("t1_en_idle", 32'(enable), 32'd0);
    check("t1_empty_end", 32'(empty), 32'd1);
    check("t1_data_keep", 32'(TX_DATA), 32'hA5);
    tx_finish = 1'b0;
    repeat (3) tick();

    // Fill while the sender is stalled in BUSY
    tx_state = 1'b1;
    push(8'h5A);
    wait_trig(10, "t2_lead");
    check("t2_lead_data", 32'(TX_DATA), 32'h5A);
    tick();
    check("t2_in_busy", 32'(trigger), 32'd0);
    for (int i = 1; i <= 8; i++) push(8'(i));
    check("t2_count8", 32'(count), 32'd8);
    check("t2_full", 32'(full), 32'd1);
    push(8'hFF);
    check("t2_drop_cnt", 32'(count), 32'd8);
    check("t2_drop_full", 32'(full), 32'd1);
    for (int i = 1; i <= 8; i++)
      frame_step(8'(i), $sformatf("t2_frame%0d", i));
    check("t2_drained", 32'(count), 32'd0);
    tx_finish = 1'b1;
    repeat (4) tick();
    check("t2_idle_en", 32'(enable), 32'd0);
    check("t2_idle_trig", 32'(trigger), 32'd0);
    check("t2_last_data", 32'(TX_DATA), 32'h08);
    tx_finish = 1'b0;
    repeat (3) tick();

    // Same-cycle push and pop at count 3
    push(8'hC1);
    wait_trig(10, "t3_lead");
    check("t3_lead_data", 32'(TX_DATA), 32'hC1);
    tick();
    push(8'hC2);
    push(8'hC3);
    push(8'hC4);
    check("t3_count3", 32'(count), 32'd3);
    mq = '{8'hC2, 8'hC3, 8'hC4};
    tx_finish = 1'b1;
    repeat (4) tick();
    wr_en   = 1'b1;
    wr_data = 8'hC5;
    tick();
    wr_en   = 1'b0;
    mq.push_back(8'hC5);
    exp_b = mq.pop_front();
    check("t3_pp_count", 32'(count), 32'd3);
    check("t3_pp_trig", 32'(trigger), 32'd1);
    check("t3_pp_data", 32'(TX_DATA), 32'(exp_b));
    tx_finish = 1'b0;
    repeat (3) tick();

    // Mixed push/pop through pointer wrap
    for (int i = 0; i < 20; i++) begin
      if (ops[i][8]) begin
        exp_b = mq.pop_front();
        frame_step(exp_b, $sformatf("t3_op%0d_pop", i));
      end else begin
        push(ops[i][7:0]);
        mq.push_back(ops[i][7:0]);
      end
      check($sformatf("t3_op%0d_cnt", i),
            32'(count), 32'(mq.size()));
    end

    // Reset during BUSY with 4 queued
    push(8'h20);
    check("t4_count4", 32'(count), 32'd4);
    reset = 1'b0;
    tick();
    check("t4_count", 32'(count), 32'd0);
    check("t4_empty", 32'(empty), 32'd1);
    check("t4_trig", 32'(trigger), 32'd0);
    check("t4_en", 32'(enable), 32'd0);
    check("t4_data", 32'(TX_DATA), 32'h00);
    reset    = 1'b1;
    tx_state = 1'b0;
    tick();

    // Watchdog: sender never goes busy
    push(8'hAA);
    push(8'hBB);
    tick();
    check("t5_trig", 32'(trigger), 32'd1);
    check("t5_data", 32'(TX_DATA), 32'hAA);
    repeat (65535) tick();
    check("t5_trig_hold", 32'(trigger), 32'd1);
    tick();
    check("t5_wd_trig", 32'(trigger), 32'd0);
    check("t5_wd_en", 32'(enable), 32'd0);
    check("t5_wd_count", 32'(count), 32'd1);
    repeat (2) tick();
    check("t5_next_trig", 32'(trigger), 32'd1);
    check("t5_next_data", 32'(TX_DATA), 32'hBB);

`ifdef UART_TXQ_OVERFLOW_FLAG_EN
    // Sticky overflow flag
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
    check("t6_full", 32'(full), 32'd1);
    check("t6_ovf0", 32'(overflow), 32'd0);
    push(8'hEE);
    check("t6_ovf_set", 32'(overflow), 32'd1);
    tick();
    check("t6_ovf_keep", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    push(8'hEF);
    check("t6_set_wins", 32'(overflow), 32'd1);
    tick();
    ovf_clr = 1'b0;
    check("t6_ovf_clr", 32'(overflow), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte queue and transmit sequencer that sits directly upstream of the UART sender.
- The CPU peripheral bus pushes bytes into a circular FIFO.
- The block pops one byte at a time, presents it on the sender's data input, and triggers a frame.
- It waits for the sender's busy/finish handshake before releasing the next byte, so the CPU never has to poll the serial line per byte.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, at least 2.
- ADDR_W, 3, log2(DEPTH).
- DATA_W, 8, byte width; fixed at 8 to match the sender.

Ports:
- sysclk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-low reset, sampled on the sysclk rising edge.
- wr_en  in  1  push request from the CPU bus, one cycle per byte.
- wr_data  in  8  byte to push.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- TX_DATA  out  8  byte presented to the sender; stable for the whole frame.
- trigger  out  1  frame-start request to the sender.
- enable  out  1  sender enable.
- tx_state  in  1  sender busy status, asynchronous to sysclk.
- tx_finish  in  1  sender frame-finish indication, asynchronous to sysclk.

Behaviour:
- Reset values (reset=0 at a sysclk edge):
  - Pointers and count = 0; full=0, empty=1.
  - TX_DATA=8'h00, trigger=0, enable=0.
  - FSM in IDLE; synchronisers cleared.
- Reset mid-frame:
  - Abandons the queued bytes and the current frame; trigger drops the next cycle.
  - Sender-side line state is the sender's responsibility.
- Synchronisers:
  - tx_state and tx_finish each pass through a 2-flop synchroniser.
  - tx_finish rise = synced value 1 while the previous synced value was 0; single-cycle detect.
- FIFO:
  - Push when wr_en && !full.
  - Pop happens only in state LOAD.
  - Pointers wrap modulo DEPTH.
  - count increments on push only, decrements on pop only, and is unchanged on a same-cycle push and pop.
  - wr_en while full: the byte is dropped; pointers and count are unchanged.
  - full = (count==DEPTH); empty = (count==0); both are registered-consistent with count.
- FSM, one transition per sysclk:
  - IDLE: enable=0, trigger=0. If !empty, go to LOAD.
  - LOAD: TX_DATA <= mem[rd_ptr]; pop; enable=1. Go to TRIG.
  - TRIG: trigger=1. When synced tx_state==1, go to BUSY and drop trigger the same edge.
  - BUSY: trigger=0, enable=1. On tx_finish rise, go to GAP.
  - GAP: one-cycle stop margin. If !empty go to LOAD, else go to IDLE (enable drops on IDLE entry).
- TX_DATA changes only in LOAD. It must never change while in TRIG or BUSY.
- Minimum latency: a push into an empty IDLE queue at cycle N gives LOAD at N+1 and trigger high at N+2.
- A push in the same cycle as the last pop is accepted; GAP then sees !empty and continues back-to-back.
- A tx_finish rise outside BUSY is ignored.
- Watchdog: TRIG held for 2^16 cycles without busy returns the FSM to IDLE with the byte discarded.

Optional Feature:
- Macro: UART_TXQ_OVERFLOW_FLAG_EN.
- With the macro defined:
  - Adds output overflow (1 bit), plus input ovf_clr (1 bit).
  - overflow is set sticky on wr_en && full.
  - It is cleared by ovf_clr or reset; set wins over a same-cycle clear.
- Without the macro: ports absent; overflowing writes are silently dropped.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE, LOAD, TRIG, BUSY, GAP).
  - Watchdog width constant TXQ_WDOG_W=16.
  - Frame width constant UART_DATA_W=8.
- One sub-module: sync_ff2, a generic 2-flop synchroniser, instanced twice.
- Storage array, pointers and FSM stay in uart_tx_queue.

Test Plan:
- Reset then single push 8'hA5 → trigger high 2 cycles later with TX_DATA=8'hA5. Model tx_state high 3 cycles later → trigger low. Pulse tx_finish → GAP, then IDLE, enable=0, empty=1.
- Push 8 bytes 0x01..0x08 back-to-back while the sender model is stalled → full=1 and count=8. 9th push 0xFF is dropped. The frames emitted carry 0x01..0x08 in order; 0xFF never appears.
- Push at the same cycle as a pop with count=3 → count stays 3. Pointer wrap after 20 mixed operations matches a reference queue.
- Assert reset=0 during BUSY with 4 bytes queued → next cycle count=0, trigger=0, enable=0, TX_DATA=0.
- Sender model never raises tx_state → after 65536 cycles in TRIG the FSM returns to IDLE and the next queued byte is loaded.
- With UART_TXQ_OVERFLOW_FLAG_EN: fill, push once more → overflow=1 and it persists. ovf_clr and a full-push in the same cycle → overflow stays 1. ovf_clr alone → overflow=0.
